// File: rtl/seven_seg_capture.sv
// Rebuilds four hex digits from a multiplexed active-low 7-seg scan.
// Ports: clk, reset, anode[3:0], cathode[6:0] -> digits[15:0],
//   digit_err[3:0], frame_done, anode_err. Optional SEG_CAPTURE_DP_EN
//   adds dp (in) and dp_out[3:0] (out).
module seven_seg_capture #(
  parameter int SETTLE = 4,
  parameter int CNT_W  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anode,
  input  logic [6:0]  cathode,
`ifdef SEG_CAPTURE_DP_EN
  input  logic        dp,
  output logic [3:0]  dp_out,
`endif
  output logic [15:0] digits,
  output logic [3:0]  digit_err,
  output logic        frame_done,
  output logic        anode_err
);

  localparam logic [1:0] S_WAIT   = 2'd0;
  localparam logic [1:0] S_SAMPLE = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(SETTLE - 1);

  logic [1:0]       st_q, st_d;
  logic [3:0]       a_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      shd_q, shd_d;
  logic [3:0]       sherr_q, sherr_d;
  logic [3:0]       seen_q, seen_d;
  logic [3:0]       seen_n;
  logic [15:0]      dig_q, dig_d;
  logic [3:0]       derr_q, derr_d;
  logic             fd_q, fd_d;
  logic             aerr_q, aerr_d;
  logic             a_chg;
  logic             legal;
  logic [3:0]       slot_oh;
  logic [3:0]       nib;
  logic             gerr;
`ifdef SEG_CAPTURE_DP_EN
  logic [3:0]       dps_q, dps_d;
  logic [3:0]       dpo_q, dpo_d;
`endif

  assign a_chg   = anode != a_q;
  assign slot_oh = ~a_q;

  always_comb begin
    legal = 1'b0;
    unique case (a_q)
      4'hE, 4'hD, 4'hB, 4'h7: legal = 1'b1;
      default:                legal = 1'b0;
    endcase
  end

  always_comb begin
    nib  = 4'h0;
    gerr = 1'b0;
    unique case (cathode)
      7'h40:   nib = 4'h0;
      7'h79:   nib = 4'h1;
      7'h24:   nib = 4'h2;
      7'h30:   nib = 4'h3;
      7'h19:   nib = 4'h4;
      7'h12:   nib = 4'h5;
      7'h02:   nib = 4'h6;
      7'h78:   nib = 4'h7;
      7'h00:   nib = 4'h8;
      7'h10:   nib = 4'h9;
      7'h08:   nib = 4'hA;
      7'h03:   nib = 4'hB;
      7'h46:   nib = 4'hC;
      7'h21:   nib = 4'hD;
      7'h06:   nib = 4'hE;
      7'h0E:   nib = 4'hF;
      default: gerr = 1'b1;
    endcase
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    shd_d   = shd_q;
    sherr_d = sherr_q;
    seen_d  = seen_q;
    seen_n  = seen_q | slot_oh;
    dig_d   = dig_q;
    derr_d  = derr_q;
    fd_d    = 1'b0;
    aerr_d  = aerr_q;
`ifdef SEG_CAPTURE_DP_EN
    dps_d   = dps_q;
    dpo_d   = dpo_q;
`endif
    unique case (st_q)
      S_WAIT: begin
        if (!a_chg) begin
          if (cnt_q == CNT_TOP) st_d = S_SAMPLE;
          else cnt_d = cnt_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        st_d = S_HOLD;
        if (legal) begin
          for (int i = 0; i < 4; i++) begin
            if (slot_oh[i]) begin
              shd_d[i*4 +: 4] = nib;
              sherr_d[i]      = gerr;
`ifdef SEG_CAPTURE_DP_EN
              dps_d[i]        = ~dp;
`endif
            end
          end
          // The write completing the set publishes on this same edge.
          if (&seen_n) begin
            dig_d  = shd_d;
            derr_d = sherr_d;
            fd_d   = 1'b1;
            seen_d = 4'h0;
`ifdef SEG_CAPTURE_DP_EN
            dpo_d  = dps_d;
`endif
          end else begin
            seen_d = seen_n;
          end
        end else if (a_q != 4'hF) begin
          aerr_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (a_chg) st_d = S_WAIT;
      end
      default: st_d = S_WAIT;
    endcase
    if (a_chg) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= S_WAIT;
      a_q     <= 4'hF;
      cnt_q   <= '0;
      shd_q   <= '0;
      sherr_q <= '0;
      seen_q  <= '0;
      dig_q   <= '0;
      derr_q  <= '0;
      fd_q    <= 1'b0;
      aerr_q  <= 1'b0;
`ifdef SEG_CAPTURE_DP_EN
      dps_q   <= '0;
      dpo_q   <= '0;
`endif
    end else begin
      st_q    <= st_d;
      a_q     <= anode;
      cnt_q   <= cnt_d;
      shd_q   <= shd_d;
      sherr_q <= sherr_d;
      seen_q  <= seen_d;
      dig_q   <= dig_d;
      derr_q  <= derr_d;
      fd_q    <= fd_d;
      aerr_q  <= aerr_d;
`ifdef SEG_CAPTURE_DP_EN
      dps_q   <= dps_d;
      dpo_q   <= dpo_d;
`endif
    end
  end

  assign digits     = dig_q;
  assign digit_err  = derr_q;
  assign frame_done = fd_q;
  assign anode_err  = aerr_q;
`ifdef SEG_CAPTURE_DP_EN
  assign dp_out     = dpo_q;
`endif

endmodule

// File: tb/tb_seven_seg_capture.sv
// Randomized and directed bench for seven_seg_capture.
// Dwell-level reference model; summary line at end.
module tb_seven_seg_capture;
  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic [15:0] digits;
  logic [3:0]  digit_err;
  logic        frame_done;
  logic        anode_err;
`ifdef SEG_CAPTURE_DP_EN
  logic        dp;
  logic [3:0]  dp_out;
  logic [3:0]  m_dp;
  logic [3:0]  e_dp;
`endif

  always #5 clk = ~clk;

  seven_seg_capture #(
    .SETTLE(SETTLE),
    .CNT_W (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .anode     (anode),
    .cathode   (cathode),
`ifdef SEG_CAPTURE_DP_EN
    .dp        (dp),
    .dp_out    (dp_out),
`endif
    .digits    (digits),
    .digit_err (digit_err),
    .frame_done(frame_done),
    .anode_err (anode_err)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [6:0]  glyph [16];
  logic [3:0]  m_nib [4];
  logic [3:0]  m_gerr;
  logic [3:0]  m_seen;
  logic [15:0] e_dig;
  logic [3:0]  e_derr;
  logic        e_aerr;
  int          e_fd = 0;
  int          o_fd = 0;
  int          o_lat = 0;
  int          o_spur = 0;
  logic [3:0]  last_a;

  function automatic logic find_glyph(input logic [6:0] c,
                                      output logic [3:0] n);
    n = 4'h0;
    for (int g = 0; g < 16; g++) begin
      if (glyph[g] == c) begin
        n = 4'(g);
        return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  // One sample per dwell: write a legal slot, flag an illegal anode.
  task automatic model_sample(input logic [3:0] a,
                              input logic [6:0] c,
                              input logic d);
    int k;
    logic [3:0] m;
    logic [3:0] n;
    k = -1;
    for (int s = 0; s < 4; s++) begin
      m = 4'b0001 << s;
      if (a == ~m) k = s;
    end
    if (k >= 0) begin
      m_gerr[k] = find_glyph(c, n);
      m_nib[k]  = n;
      m_seen[k] = 1'b1;
`ifdef SEG_CAPTURE_DP_EN
      m_dp[k]   = ~d;
`endif
      if (m_seen == 4'hF) begin
        e_dig  = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
        e_derr = m_gerr;
        m_seen = 4'h0;
        e_fd++;
`ifdef SEG_CAPTURE_DP_EN
        e_dp   = m_dp;
`endif
      end
    end else if (a != 4'hF) begin
      e_aerr = 1'b1;
    end
  endtask

  // Hold one anode/cathode pair for len cycles and observe the DUT.
  task automatic dwell(input logic [3:0] a, input logic [6:0] c,
                       input logic d, input int len);
    logic [15:0] pd;
    logic [3:0]  pe;
    for (int i = 0; i < len; i++) begin
      anode   = a;
      cathode = c;
`ifdef SEG_CAPTURE_DP_EN
      dp      = d;
`endif
      pd = digits;
      pe = digit_err;
      @(posedge clk);
      #1;
      if (len >= SETTLE + 2 && i == SETTLE + 1) model_sample(a, c, d);
      if (frame_done === 1'b1) begin
        o_fd++;
        o_lat = i + 1;
      end else if (digits !== pd || digit_err !== pe) begin
        o_spur++;
      end
    end
    last_a = a;
  endtask

  task automatic reset_dut();
    reset   = 1'b1;
    anode   = 4'hF;
    cathode = 7'h7F;
`ifdef SEG_CAPTURE_DP_EN
    dp      = 1'b1;
    m_dp    = 4'h0;
    e_dp    = 4'h0;
`endif
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    m_seen = 4'h0;
    m_gerr = 4'h0;
    for (int s = 0; s < 4; s++) m_nib[s] = 4'h0;
    e_dig  = 16'h0;
    e_derr = 4'h0;
    e_aerr = 1'b0;
    last_a = 4'hF;
  endtask

  task automatic test_reset();
    reset_dut();
    n_vec++;
    if (digits !== 16'h0) begin
      n_err++; $display("FAIL reset_digits got %h want 0000", digits);
    end
    n_vec++;
    if (digit_err !== 4'h0) begin
      n_err++; $display("FAIL reset_derr got %h want 0", digit_err);
    end
    n_vec++;
    if (frame_done !== 1'b0) begin
      n_err++; $display("FAIL reset_fd got %b want 0", frame_done);
    end
    n_vec++;
    if (anode_err !== 1'b0) begin
      n_err++; $display("FAIL reset_aerr got %b want 0", anode_err);
    end
  endtask

  task automatic test_scan();
    int f0;
    f0 = o_fd;
    dwell(4'b1110, 7'h79, 1'b1, 8);
    dwell(4'b1101, 7'h24, 1'b1, 8);
    dwell(4'b1011, 7'h30, 1'b1, 8);
    dwell(4'b0111, 7'h19, 1'b1, 8);
    n_vec++;
    if (o_fd - f0 != 1) begin
      n_err++; $display("FAIL scan_fd_count got %0d want 1", o_fd - f0);
    end
    n_vec++;
    if (digits !== 16'h4321) begin
      n_err++; $display("FAIL scan_digits got %h want 4321", digits);
    end
    n_vec++;
    if (digit_err !== 4'h0) begin
      n_err++; $display("FAIL scan_derr got %h want 0", digit_err);
    end
    n_vec++;
    if (o_lat != SETTLE + 2) begin
      n_err++; $display("FAIL scan_latency got %0d want %0d", o_lat, SETTLE + 2);
    end
  endtask

  task automatic test_bad_glyph();
    dwell(4'b1110, 7'h7F, 1'b1, 8);
    dwell(4'b1101, 7'h24, 1'b1, 8);
    dwell(4'b1011, 7'h30, 1'b1, 8);
    dwell(4'b0111, 7'h19, 1'b1, 8);
    n_vec++;
    if (digit_err !== 4'b0001) begin
      n_err++; $display("FAIL glyph_derr got %b want 0001", digit_err);
    end
    n_vec++;
    if (digits !== 16'h4320) begin
      n_err++; $display("FAIL glyph_digits got %h want 4320", digits);
    end
  endtask

  task automatic test_illegal_anode();
    int f0;
    f0 = o_fd;
    dwell(4'b1100, 7'h40, 1'b1, 8);
    n_vec++;
    if (anode_err !== 1'b1) begin
      n_err++; $display("FAIL illegal_aerr got %b want 1", anode_err);
    end
    n_vec++;
    if (o_fd != f0) begin
      n_err++; $display("FAIL illegal_fd got %0d want %0d", o_fd, f0);
    end
    dwell(4'b1110, 7'h40, 1'b1, 8);
    dwell(4'b1111, 7'h7F, 1'b1, 8);
    dwell(4'b1101, 7'h79, 1'b1, 8);
    n_vec++;
    if (anode_err !== 1'b1) begin
      n_err++; $display("FAIL sticky_aerr got %b want 1", anode_err);
    end
  endtask

  task automatic test_glitch();
    int f0;
    reset_dut();
    f0 = o_fd;
    dwell(4'b1110, 7'h79, 1'b1, 8);
    dwell(4'b1101, 7'h24, 1'b1, SETTLE - 1);
    dwell(4'b1011, 7'h30, 1'b1, 8);
    dwell(4'b0111, 7'h19, 1'b1, 8);
    n_vec++;
    if (o_fd != f0) begin
      n_err++; $display("FAIL glitch_sampled got %0d want %0d", o_fd, f0);
    end
    dwell(4'b1101, 7'h12, 1'b1, 8);
    n_vec++;
    if (o_fd != f0 + 1) begin
      n_err++; $display("FAIL glitch_fd got %0d want %0d", o_fd, f0 + 1);
    end
    n_vec++;
    if (digits !== 16'h4351) begin
      n_err++; $display("FAIL glitch_digits got %h want 4351", digits);
    end
  endtask

  task automatic test_reset_midframe();
    int f0;
    f0 = o_fd;
    dwell(4'b1110, 7'h79, 1'b1, 8);
    dwell(4'b1101, 7'h24, 1'b1, 8);
    dwell(4'b1011, 7'h30, 1'b1, 8);
    reset_dut();
    dwell(4'b1110, 7'h08, 1'b1, 8);
    dwell(4'b1101, 7'h03, 1'b1, 8);
    dwell(4'b1011, 7'h46, 1'b1, 8);
    dwell(4'b0111, 7'h21, 1'b1, 8);
    n_vec++;
    if (o_fd - f0 != 1) begin
      n_err++; $display("FAIL midreset_fd got %0d want 1", o_fd - f0);
    end
    n_vec++;
    if (digits !== 16'hDCBA) begin
      n_err++; $display("FAIL midreset_digits got %h want dcba", digits);
    end
  endtask

`ifdef SEG_CAPTURE_DP_EN
  task automatic test_dp();
    reset_dut();
    dwell(4'b1110, 7'h40, 1'b1, 8);
    dwell(4'b1101, 7'h40, 1'b1, 8);
    dwell(4'b1011, 7'h40, 1'b0, 8);
    dwell(4'b0111, 7'h40, 1'b1, 8);
    n_vec++;
    if (dp_out !== 4'b0100) begin
      n_err++; $display("FAIL dp_out got %b want 0100", dp_out);
    end
  endtask
`endif

  task automatic test_random();
    logic [3:0] a;
    logic [6:0] c;
    logic       d;
    int         r;
    int         len;
    reset_dut();
    for (int t = 0; t < 120; t++) begin
      do begin
        r = $urandom_range(0, 19);
        if (r < 14) a = ~(4'b0001 << $urandom_range(0, 3));
        else if (r < 19) a = 4'hF;
        else a = 4'($urandom_range(0, 15));
      end while (a == last_a);
      if ($urandom_range(0, 5) == 0) c = 7'($urandom_range(0, 127));
      else c = glyph[$urandom_range(0, 15)];
      d = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) len = $urandom_range(1, SETTLE);
      else len = $urandom_range(SETTLE + 2, SETTLE + 6);
      dwell(a, c, d, len);
      n_vec++;
      if (digits !== e_dig) begin
        n_err++; $display("FAIL rnd_digits t=%0d got %h want %h", t, digits, e_dig);
      end
      n_vec++;
      if (digit_err !== e_derr) begin
        n_err++; $display("FAIL rnd_derr t=%0d got %h want %h", t, digit_err, e_derr);
      end
      n_vec++;
      if (anode_err !== e_aerr) begin
        n_err++; $display("FAIL rnd_aerr t=%0d got %b want %b", t, anode_err, e_aerr);
      end
      n_vec++;
      if (o_fd != e_fd) begin
        n_err++; $display("FAIL rnd_fd t=%0d got %0d want %0d", t, o_fd, e_fd);
      end
`ifdef SEG_CAPTURE_DP_EN
      n_vec++;
      if (dp_out !== e_dp) begin
        n_err++; $display("FAIL rnd_dp t=%0d got %b want %b", t, dp_out, e_dp);
      end
`endif
    end
    n_vec++;
    if (o_spur != 0) begin
      n_err++; $display("FAIL rnd_spurious got %0d want 0", o_spur);
    end
  endtask

  initial begin
    glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    reset   = 1'b1;
    anode   = 4'hF;
    cathode = 7'h7F;
`ifdef SEG_CAPTURE_DP_EN
    dp      = 1'b1;
`endif
    test_reset();
    e_fd = o_fd;
    test_scan();
    test_bad_glyph();
    test_illegal_anode();
    test_glitch();
    test_reset_midframe();
`ifdef SEG_CAPTURE_DP_EN
    test_dp();
`endif
    e_fd = o_fd;
    o_spur = 0;
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
